// File: rtl/mci_port_arbiter_pkg.sv
// rtl/mci_port_arbiter_pkg.sv - block port request/response types for the memory controller interface
package mci_port_arbiter_pkg;

    typedef struct packed {
        logic         valid;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } mci_request_t;

    typedef struct packed {
        logic         ready;
        logic [127:0] data;
    } mci_response_t;

endpackage

// File: rtl/mci_port_arbiter.sv
// rtl/mci_port_arbiter.sv - merges fetch and data ports onto one 128-bit block port, stores as block RMW
module mci_port_arbiter
    import mci_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output mci_request_t  mem_req,
    input  mci_response_t mem_res,
    output logic          o_retry
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_WR_ISSUE = 3'd3;
    localparam logic [2:0] S_WR_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic          is_data;
    logic          op_we;
    logic [1:0]    word_sel;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic [127:0]  blk_buf;
    logic [TW-1:0] tmo_cnt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    function automatic logic [31:0] pick_word(input logic [127:0] blk, input logic [1:0] sel);
        return blk[{sel, 5'b0} +: 32];
    endfunction

    // Replace only the enabled bytes of the selected word; the rest of the block is written back as read.
    function automatic logic [127:0] merge_block(input logic [127:0] blk, input logic [1:0] sel,
                                                 input logic [31:0] wd, input logic [3:0] be);
        logic [127:0] blk_m;
        logic [31:0]  w;
        w = pick_word(blk, sel);
        for (int k = 0; k < 4; k++) begin
            if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
        end
        blk_m = blk;
        blk_m[{sel, 5'b0} +: 32] = w;
        return blk_m;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            is_data  <= 1'b0;
            op_we    <= 1'b0;
            word_sel <= 2'd0;
            st_wdata <= 32'd0;
            st_be    <= 4'd0;
            blk_buf  <= 128'd0;
            tmo_cnt  <= '0;
            mem_req  <= '0;
            if_ack   <= 1'b0;
            if_rdata <= 32'd0;
            d_ack    <= 1'b0;
            d_rdata  <= 32'd0;
            o_retry  <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            o_retry <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Data port wins a tie with the fetch port.
                    if (d_req || if_req) begin
                        is_data       <= d_req;
                        op_we         <= d_req & d_we;
                        word_sel      <= d_req ? d_addr[3:2] : if_addr[3:2];
                        st_wdata      <= d_wdata;
                        st_be         <= d_be;
                        mem_req.valid <= 1'b1;
                        mem_req.rw    <= 1'b0;
                        mem_req.addr  <= d_req ? {d_addr[31:4], 4'h0} : {if_addr[31:4], 4'h0};
                        state         <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    mem_req.valid <= 1'b0;
                    tmo_cnt       <= '0;
                    state         <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_res.ready) begin
                        blk_buf <= mem_res.data;
                        if (op_we) begin
                            mem_req.valid <= 1'b1;
                            mem_req.rw    <= 1'b1;
                            mem_req.data  <= merge_block(mem_res.data, word_sel, st_wdata, st_be);
                            state         <= S_WR_ISSUE;
                        end else begin
                            if (is_data) begin
                                d_ack   <= 1'b1;
                                d_rdata <= pick_word(mem_res.data, word_sel);
                            end else begin
                                if_ack   <= 1'b1;
                                if_rdata <= pick_word(mem_res.data, word_sel);
                            end
                            state <= S_RESP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req.valid <= 1'b1;
                        o_retry       <= 1'b1;
                        state         <= S_RD_ISSUE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WR_ISSUE: begin
                    mem_req.valid <= 1'b0;
                    tmo_cnt       <= '0;
                    state         <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    // Stores report the pre-store word on d_rdata.
                    if (mem_res.ready) begin
                        d_ack   <= 1'b1;
                        d_rdata <= pick_word(blk_buf, word_sel);
                        state   <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req.valid <= 1'b1;
                        o_retry       <= 1'b1;
                        state         <= S_WR_ISSUE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mci_port_arbiter.sv
// tb/tb_mci_port_arbiter.sv - randomized bench for mci_port_arbiter against a word-level memory model
module tb_mci_port_arbiter;
    import mci_port_arbiter_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = 32'd0;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = 32'd0;
    logic [31:0]   d_wdata = 32'd0;
    logic [3:0]    d_be = 4'd0;
    logic          d_ack;
    logic [31:0]   d_rdata;
    mci_request_t  mem_req;
    mci_response_t mem_res;
    logic          o_retry;

    logic          mem_ready = 1'b0;
    logic [127:0]  mem_rdata;
    logic [127:0]  mem [0:511];
    logic [31:0]   ref_w [0:2047];

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } issue_t;

    issue_t issued[$];
    int     vcyc[$];
    int     cyc = 0, dack_cyc = 0, if_ack_cnt = 0, retry_cnt = 0;
    int     lat_lo = 0, lat_hi = 0;
    bit     mem_en = 1'b1;
    int     n_checks = 0, n_errors = 0;

    bit           pend = 1'b0, pend_rw = 1'b0;
    int           pend_lat = 0;
    logic [31:0]  pend_addr = 32'd0;
    logic [127:0] pend_data = 128'd0;

    assign mem_rdata = mem[mem_req.addr[12:4]];
    assign mem_res   = {mem_ready, mem_rdata};

    always #5 i_clk = ~i_clk;

    mci_port_arbiter #(.TIMEOUT(8)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_res  (mem_res),
        .o_retry  (o_retry)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_block(input logic [8:0] b);
        return {ref_w[{b, 2'd3}], ref_w[{b, 2'd2}], ref_w[{b, 2'd1}], ref_w[{b, 2'd0}]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        ref_w[a[12:2]] = v;
        mem[a[12:4]][32*a[3:2] +: 32] = v;
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        for (int k = 0; k < 4; k++) begin
            if (be[k]) ref_w[a[12:2]][8*k +: 8] = wd[8*k +: 8];
        end
    endtask

    // Memory responder and bus monitor; ready comes pend_lat cycles into the WAIT phase.
    initial begin
        forever begin
            @(negedge i_clk);
            cyc++;
            mem_ready = 1'b0;
            if (pend) begin
                if (pend_lat == 0) begin
                    if (mem_en) begin
                        mem_ready = 1'b1;
                        pend = 1'b0;
                        if (pend_rw) mem[pend_addr[12:4]] = pend_data;
                    end
                end else begin
                    pend_lat--;
                end
            end
            if (mem_req.valid) begin
                pend      = 1'b1;
                pend_rw   = mem_req.rw;
                pend_addr = mem_req.addr;
                pend_data = mem_req.data;
                pend_lat  = int'($urandom_range(lat_hi, lat_lo));
                issued.push_back('{mem_req.rw, mem_req.addr, mem_req.data});
                vcyc.push_back(cyc);
            end
            if (if_ack) if_ack_cnt++;
            if (d_ack) dack_cyc = cyc;
            if (o_retry) retry_cnt++;
        end
    end

    task automatic xact(input bit dsel, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int lat);
        bit seen;
        seen = 1'b0;
        rd   = 32'd0;
        lat  = 0;
        @(negedge i_clk);
        if (dsel) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge i_clk);
            lat++;
            if (dsel ? d_ack : if_ack) begin
                seen = 1'b1;
                rd   = dsel ? d_rdata : if_rdata;
            end
        end
        if (dsel) d_req = 1'b0;
        else      if_req = 1'b0;
        check("ack_seen", 128'(seen), 128'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 128'(mem_req.valid), 128'd0);
        check({tag, "_addr"},  128'(mem_req.addr),  128'd0);
        check({tag, "_acks"},  128'({if_ack, d_ack, o_retry}), 128'd0);
        check({tag, "_rdata"}, {64'd0, if_rdata, d_rdata}, 128'd0);
    endtask

    logic [31:0] rd_a, rd_b;
    int          lat_a, lat_b, acks0;

    initial begin
        for (int b = 0; b < 512; b++) begin
            for (int w = 0; w < 4; w++) set_word({19'd0, 9'(b), 2'(w), 2'd0}, (b < 16) ? $urandom : 32'h0000_0013);
        end
        set_word(32'h00, 32'h0000_0013);
        set_word(32'h04, 32'h0030_0093);
        set_word(32'h08, 32'h0020_0113);
        set_word(32'h0C, 32'h00D0_0193);
        set_word(32'h1C, 32'h4011_82B3);
        set_word(32'h6C, 32'h063A_0A13);

        #12;
        check("rst_mem_data", mem_req.data, 128'd0);
        check_reset_outputs("rst");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Fetches from the preloaded program, zero memory latency.
        issued.delete();
        xact(1'b0, 1'b0, 32'h1C, 32'd0, 4'd0, rd_a, lat_a);
        check("f1c_rdata", 128'(rd_a), 128'h4011_82B3);
        check("f1c_lat", 128'(lat_a), 128'd3);
        check("f1c_req", {issued[0].rw, issued[0].addr}, {1'b0, 32'h10});
        xact(1'b0, 1'b0, 32'h6C, 32'd0, 4'd0, rd_a, lat_a);
        check("f6c_rdata", 128'(rd_a), 128'h063A_0A13);

        // Full-word store at 0x0.
        issued.delete();
        xact(1'b1, 1'b1, 32'h0, 32'h0000_0011, 4'hF, rd_a, lat_a);
        ref_store(32'h0, 32'h0000_0011, 4'hF);
        check("st0_lat", 128'(lat_a), 128'd5);
        check("st0_old", 128'(rd_a), 128'h0000_0013);
        check("st0_nreq", 128'(issued.size()), 128'd2);
        check("st0_rd", {issued[0].rw, issued[0].addr}, {1'b0, 32'h0});
        check("st0_wr", {issued[1].rw, issued[1].addr}, {1'b1, 32'h0});
        check("st0_wdata", issued[1].data, 128'h00D0_0193_0020_0113_0030_0093_0000_0011);

        // Byte store into a NOP block, then read it back.
        issued.delete();
        xact(1'b1, 1'b1, 32'h1006, 32'h00AB_0000, 4'b0100, rd_a, lat_a);
        ref_store(32'h1006, 32'h00AB_0000, 4'b0100);
        check("st1006_word1", 128'(issued[1].data[63:32]), 128'h00AB_0013);
        xact(1'b1, 1'b0, 32'h1004, 32'd0, 4'd0, rd_a, lat_a);
        check("ld1004", 128'(rd_a), 128'h00AB_0013);

        // Empty byte mask: RMW still happens, contents unchanged.
        issued.delete();
        xact(1'b1, 1'b1, 32'h1010, 32'hDEAD_BEEF, 4'b0000, rd_a, lat_a);
        check("be0_nreq", 128'(issued.size()), 128'd2);
        check("be0_block", mem[9'h101], ref_block(9'h101));

        // Simultaneous requests: data first, fetch two cycles after d_ack.
        issued.delete();
        vcyc.delete();
        fork
            xact(1'b1, 1'b0, 32'h0000_0104, 32'd0, 4'd0, rd_a, lat_a);
            xact(1'b0, 1'b0, 32'h0000_001C, 32'd0, 4'd0, rd_b, lat_b);
        join
        check("tie_drdata", 128'(rd_a), 128'(ref_w[32'h104 >> 2]));
        check("tie_ifrdata", 128'(rd_b), 128'h4011_82B3);
        check("tie_order", {issued[0].addr, issued[1].addr}, {32'h100, 32'h10});
        check("tie_gap", 128'(vcyc[1] - dack_cyc), 128'd2);

        // Memory never ready: re-issue every TIMEOUT+1 cycles with o_retry.
        mem_en = 1'b0;
        @(negedge i_clk);
        issued.delete();
        vcyc.delete();
        retry_cnt = 0;
        acks0 = if_ack_cnt;
        if_req = 1'b1;
        if_addr = 32'h6C;
        repeat (40) @(negedge i_clk);
        check("tmo_pulses", 128'(vcyc.size()), 128'd5);
        for (int i = 1; i < vcyc.size(); i++) check("tmo_period", 128'(vcyc[i] - vcyc[i-1]), 128'd9);
        check("tmo_retries", 128'(retry_cnt), 128'(vcyc.size() - 1));
        check("tmo_same_addr", 128'(issued[issued.size()-1].addr), 128'h60);
        mem_en = 1'b1;
        lat_b = 0;
        for (int i = 0; i < 60 && lat_b == 0; i++) begin
            @(negedge i_clk);
            if (if_ack) begin
                lat_b = 1;
                rd_b  = if_rdata;
            end
        end
        if_req = 1'b0;
        check("tmo_ack_seen", 128'(lat_b), 128'd1);
        check("tmo_rdata", 128'(rd_b), 128'h063A_0A13);
        repeat (20) @(negedge i_clk);
        check("tmo_one_ack", 128'(if_ack_cnt - acks0), 128'd1);

        // Reset while waiting for a read; memory answers after reset is released.
        lat_lo = 3;
        lat_hi = 3;
        @(negedge i_clk);
        if_req = 1'b1;
        if_addr = 32'h1C;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        if_req = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        issued.delete();
        acks0 = if_ack_cnt;
        repeat (10) @(negedge i_clk);
        check("arst_no_ack", 128'(if_ack_cnt - acks0), 128'd0);
        check("arst_no_req", 128'(issued.size()), 128'd0);
        lat_lo = 0;
        lat_hi = 0;
        xact(1'b0, 1'b0, 32'h1C, 32'd0, 4'd0, rd_a, lat_a);
        check("arst_next_rdata", 128'(rd_a), 128'h4011_82B3);
        check("arst_next_lat", 128'(lat_a), 128'd3);

        // Randomized traffic against the word-level model.
        lat_hi = 3;
        for (int n = 0; n < 80; n++) begin
            logic        dsel, we;
            logic [31:0] a, wd, exp_w, rd;
            logic [3:0]  be;
            int          lat;
            dsel  = 1'($urandom_range(1, 0));
            we    = dsel & 1'($urandom_range(1, 0));
            a     = 32'($urandom_range(32'h1FFF, 0));
            wd    = $urandom;
            be    = 4'($urandom);
            exp_w = ref_w[a[12:2]];
            issued.delete();
            xact(dsel, we, a, wd, be, rd, lat);
            check("rnd_rdata", 128'(rd), 128'(exp_w));
            check("rnd_nreq", 128'(issued.size()), we ? 128'd2 : 128'd1);
            if (issued.size() > 0) check("rnd_addr", 128'(issued[0].addr), 128'({a[31:4], 4'h0}));
            if (we) begin
                ref_store(a, wd, be);
                check("rnd_block", mem[a[12:4]], ref_block(a[12:4]));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
